// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaler tick advances the LED bank by rotate-left,
// rotate-right, split counter-rotating halves, or a bouncing single light.
module led_pattern_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DIV_W      = 23,
  parameter logic [WIDTH-1:0] SEED       = 8'b1110_0111,
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0]    POS_MAX  = PW'(WIDTH - 1);
  localparam logic [DIV_W-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    SPLIT  = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;

  mode_e            mode_in;
  logic [DIV_W-1:0] tick_mask;
  logic             tick;

  function automatic logic [WIDTH-1:0] bounce_led(input logic [PW-1:0] p);
    logic [WIDTH-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return ACTIVE_LOW ? ~oh : oh;
  endfunction

  assign mode_in = mode_e'(mode);

  // Low L = DIV_W - 2*speed bits of the free-running counter set the tick period.
  assign tick_mask = CNT_ONES >> {speed, 1'b0};
  assign tick      = en && ((cnt_q & tick_mask) == tick_mask);

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    led_d  = led_q;
    step_d = 1'b0;
    pos_d  = pos_q;
    dir_d  = dir_q;

    if (mode_in != mode_q) begin
      mode_d = mode_in;
      cnt_d  = '0;
      if (mode_in == BOUNCE) begin
        pos_d = '0;
        dir_d = DIR_UP;
        led_d = bounce_led('0);
      end else begin
        led_d = SEED;
      end
    end else begin
      if (en) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (tick) begin
        step_d = 1'b1;
        unique case (mode_q)
          ROT_L: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          ROT_R: led_d = {led_q[0], led_q[WIDTH-1:1]};
          // Upper half rotates toward the MSB, lower half toward bit 0.
          SPLIT: led_d = {led_q[WIDTH-2:H], led_q[WIDTH-1], led_q[0], led_q[H-1:1]};
          BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_MAX) begin
                dir_d = DIR_DOWN;
                pos_d = POS_MAX - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = PW'(1);
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
            led_d = bounce_led(pos_d);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= ROT_L;
      led_q  <= SEED;
      step_q <= 1'b0;
      pos_q  <= '0;
      dir_q  <= DIR_UP;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      step_q <= step_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized control,
// checked every cycle against a tick-count based reference model.
module tb_led_pattern_gen;

  localparam int          W      = 8;
  localparam int          DW     = 8;
  localparam logic [7:0]  SEED_V = 8'hE7;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic       step;

  int checks = 0;
  int errors = 0;

  // Reference state: active mode, prescaler count, ticks since mode entry.
  int m_mode, m_cnt, m_k;
  bit m_step;

  led_pattern_gen #(
    .WIDTH(W),
    .DIV_W(DW),
    .SEED(SEED_V),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .speed(speed),
    .led(led),
    .step(step)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
    int v, s;
    v = int'(x);
    s = r % 8;
    return 8'(((v << s) | (v >> (8 - s))) & 255);
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x, input int r);
    int v, s;
    v = int'(x);
    s = r % 4;
    return 4'(((v << s) | (v >> (4 - s))) & 15);
  endfunction

  // Expected LED value after k ticks in mode md, starting from the entry pattern.
  function automatic logic [7:0] exp_led(input int md, input int k);
    logic [7:0] s;
    int p, pos;
    s = SEED_V;
    case (md)
      0: return rotl8(s, k);
      1: return rotl8(s, (8 - (k % 8)) % 8);
      2: return {rotl4(s[7:4], k), rotl4(s[3:0], (4 - (k % 4)) % 4)};
      default: begin
        p   = k % 14;
        pos = (p <= 7) ? p : 14 - p;
        return 8'(~(1 << pos) & 255);
      end
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_k    = 0;
    m_step = 1'b0;
  endtask

  task automatic model_edge();
    int per;
    if (!rst_n) begin
      model_reset();
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cnt  = 0;
      m_k    = 0;
      m_step = 1'b0;
    end else if (en) begin
      per    = 1 << (DW - 2 * int'(speed));
      m_step = ((m_cnt % per) == per - 1);
      if (m_step) m_k++;
      m_cnt = (m_cnt + 1) % (1 << DW);
    end else begin
      m_step = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("led_model", {24'd0, led}, {24'd0, exp_led(m_mode, m_k)});
    chk("step_model", {31'd0, step}, {31'd0, m_step});
  endtask

  // Returns number of cycles until step is seen, or -1 if the budget expires.
  task automatic wait_step(input int budget, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < budget) begin
      cycle();
      i++;
      if (step === 1'b1) n = i;
    end
  endtask

  task automatic apply_reset(input logic [1:0] md, input logic [1:0] sp, input logic e);
    rst_n = 1'b0;
    mode  = md;
    speed = sp;
    en    = e;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  logic [7:0] rotr_tab [3]  = '{8'hF3, 8'hF9, 8'hFC};
  logic [7:0] split_tab [4] = '{8'hDB, 8'hBD, 8'h7E, 8'hE7};
  logic [7:0] bnc_tab [14]  = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                                8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  initial begin
    int n;
    model_reset();

    // Reset state, then ROT_L at the slowest rate.
    repeat (3) cycle();
    chk("reset_led", {24'd0, led}, 32'hE7);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (255) cycle();
    chk("pre_tick_led", {24'd0, led}, 32'hE7);
    cycle();
    chk("tick256_led", {24'd0, led}, 32'hCF);
    chk("tick256_step", {31'd0, step}, 32'd1);
    cycle();
    chk("tick257_step", {31'd0, step}, 32'd0);
    repeat (255) cycle();
    chk("tick512_led", {24'd0, led}, 32'h9F);

    // ROT_R, speed 3.
    apply_reset(2'd1, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_step(20, n);
      chk("rotr_interval", n, (i == 0) ? 32'd5 : 32'd4);
      chk("rotr_led", {24'd0, led}, {24'd0, rotr_tab[i]});
    end

    // SPLIT, speed 2.
    apply_reset(2'd2, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_step(40, n);
      chk("split_interval", n, (i == 0) ? 32'd17 : 32'd16);
      chk("split_led", {24'd0, led}, {24'd0, split_tab[i]});
    end

    // Mid-count switch into BOUNCE, then one full sweep.
    apply_reset(2'd0, 2'd3, 1'b1);
    repeat (6) cycle();
    mode = 2'd3;
    cycle();
    chk("bounce_entry_led", {24'd0, led}, 32'hFE);
    chk("bounce_entry_step", {31'd0, step}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      wait_step(8, n);
      chk("bounce_interval", n, 32'd4);
      chk("bounce_led", {24'd0, led}, {24'd0, bnc_tab[i]});
    end

    // Freeze, mode change while disabled, then first step after enabling.
    speed = 2'd1;
    repeat (10) cycle();
    en = 1'b0;
    repeat (100) cycle();
    mode = 2'd1;
    cycle();
    chk("disabled_mode_led", {24'd0, led}, 32'hE7);
    chk("disabled_mode_step", {31'd0, step}, 32'd0);
    en = 1'b1;
    wait_step(100, n);
    chk("enable_first_step", n, 32'd64);

    // Asynchronous reset between clock edges.
    speed = 2'd3;
    repeat (7) cycle();
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_led", {24'd0, led}, 32'hE7);
    chk("async_reset_step", {31'd0, step}, 32'd0);
    model_reset();
    cycle();
    mode  = 2'd0;
    speed = 2'd3;
    en    = 1'b1;
    rst_n = 1'b1;
    wait_step(10, n);
    chk("post_reset_first_step", n, 32'd4);

    // Randomized control inputs.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(1, 3));
      en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
